imem_fetch_unit: RTL and testbench

- Parametrised, clocked successor to the combinational instruction memory of the sequential Y86-64 core.
- Byte-addressed instruction store with a program-load write port, a registered fetch with valid/ready handshake, and a power-up clear sequencer.
- Sits between the fetch stage (PC in, icode/ifun byte plus 9-byte tail out) and the testbench/loader that writes the program image.

---
 rtl/imem_pkg.sv | 24 ++
 rtl/imem_fetch_unit_if.sv | 32 +++
 rtl/imem_byte_window.sv | 30 +++
 rtl/imem_fetch_unit.sv | 118 +++++++++++
 tb/tb_imem_fetch_unit.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the clocked Y86-64 instruction store and its users.
package imem_pkg;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    localparam int FETCH_BYTES_DEF = 10;

    localparam logic [3:0] ICODE_HALT   = 4'h0;
    localparam logic [3:0] ICODE_NOP    = 4'h1;
    localparam logic [3:0] ICODE_IRMOVQ = 4'h3;
    localparam logic [3:0] ICODE_RMMOVQ = 4'h4;
    localparam logic [3:0] ICODE_OPQ    = 4'h6;
    localparam logic [3:0] ICODE_JXX    = 4'h7;
    localparam logic [3:0] ICODE_CALL   = 4'h8;
    localparam logic [3:0] ICODE_RET    = 4'h9;

    function automatic logic [7:0] make_op(input logic [3:0] icode, input logic [3:0] ifun);
        return {icode, ifun};
    endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Load and fetch handshake bundle between the instruction store and its loader / fetch stage.
interface imem_fetch_unit_if
    import imem_pkg::*;
#(
    parameter int AW          = 64,
    parameter int FETCH_BYTES = FETCH_BYTES_DEF
);
    logic                           ld_valid;
    logic                           ld_ready;
    logic [AW-1:0]                  ld_addr;
    logic [7:0]                     ld_data;
    logic                           ld_error;
    logic                           req_valid;
    logic                           req_ready;
    logic [AW-1:0]                  req_pc;
    logic                           rsp_valid;
    logic                           rsp_ready;
    logic [7:0]                     rsp_byte0;
    logic [8*(FETCH_BYTES-1)-1:0]   rsp_tail;
    logic                           rsp_error;
    logic                           init_done;

    modport master (
        output ld_valid, ld_addr, ld_data, req_valid, req_pc, rsp_ready,
        input  ld_ready, ld_error, req_ready, rsp_valid, rsp_byte0, rsp_tail, rsp_error, init_done
    );

    modport slave (
        input  ld_valid, ld_addr, ld_data, req_valid, req_pc, rsp_ready,
        output ld_ready, ld_error, req_ready, rsp_valid, rsp_byte0, rsp_tail, rsp_error, init_done
    );
endinterface

// File: rtl/imem_byte_window.sv
// Combinational fetch window: byte0 plus tail bytes at pc, zero-filled past the end of the store.
module imem_byte_window #(
    parameter int DEPTH       = 2048,
    parameter int AW          = 64,
    parameter int FETCH_BYTES = 10
) (
    input  logic [7:0]                   mem_i [DEPTH],
    input  logic [AW-1:0]                pc_i,
    output logic [7:0]                   byte0_o,
    output logic [8*(FETCH_BYTES-1)-1:0] tail_o,
    output logic                         error_o
);
    localparam int IW = $clog2(DEPTH);

    logic in_range;

    // Range checks use the full-width address so high PCs never alias into the array.
    assign in_range = pc_i < AW'(DEPTH);
    assign error_o  = !in_range;
    assign byte0_o  = in_range ? mem_i[pc_i[IW-1:0]] : 8'h00;

    generate
        for (genvar gi = 0; gi < FETCH_BYTES - 1; gi++) begin : g_tail
            logic [AW:0] addr;
            assign addr = {1'b0, pc_i} + (AW+1)'(gi + 1);
            assign tail_o[8*gi +: 8] = (in_range && (addr < (AW+1)'(DEPTH)))
                                     ? mem_i[addr[IW-1:0]] : 8'h00;
        end
    endgenerate
endmodule

// File: rtl/imem_fetch_unit.sv
// Clocked Y86-64 instruction store: zero-fill sequencer, program-load port and
// registered fetch with valid/ready handshake; loads take priority over fetches.
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int DEPTH       = 2048,
    parameter int AW          = 64,
    parameter int FETCH_BYTES = FETCH_BYTES_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    imem_fetch_unit_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int TW = 8 * (FETCH_BYTES - 1);

    logic [7:0]    mem_q [DEPTH];
    state_e        state_q, state_d;
    logic [IW-1:0] cnt_q, cnt_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_byte0_q, rsp_byte0_d;
    logic [TW-1:0] rsp_tail_q, rsp_tail_d;
    logic          rsp_error_q, rsp_error_d;
    logic          ld_error_q, ld_error_d;

    logic          run;
    logic          ld_fire;
    logic          ld_in_range;
    logic          req_ready;
    logic          req_fire;
    logic [7:0]    win_byte0;
    logic [TW-1:0] win_tail;
    logic          win_error;

    assign run         = (state_q == RUN);
    assign ld_in_range = bus.ld_addr < AW'(DEPTH);
    assign ld_fire     = bus.ld_valid && run;
    assign req_ready   = run && !bus.ld_valid && (!rsp_valid_q || bus.rsp_ready);
    assign req_fire    = bus.req_valid && req_ready;

    assign bus.ld_ready  = run;
    assign bus.req_ready = req_ready;
    assign bus.ld_error  = ld_error_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_byte0 = rsp_byte0_q;
    assign bus.rsp_tail  = rsp_tail_q;
    assign bus.rsp_error = rsp_error_q;
    assign bus.init_done = run;

    imem_byte_window #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .FETCH_BYTES(FETCH_BYTES)
    ) u_window (
        .mem_i  (mem_q),
        .pc_i   (bus.req_pc),
        .byte0_o(win_byte0),
        .tail_o (win_tail),
        .error_o(win_error)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= INIT;
            cnt_q       <= '0;
            rsp_valid_q <= 1'b0;
            rsp_byte0_q <= '0;
            rsp_tail_q  <= '0;
            rsp_error_q <= 1'b0;
            ld_error_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_byte0_q <= rsp_byte0_d;
            rsp_tail_q  <= rsp_tail_d;
            rsp_error_q <= rsp_error_d;
            ld_error_q  <= ld_error_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rsp_valid_d = rsp_valid_q;
        rsp_byte0_d = rsp_byte0_q;
        rsp_tail_d  = rsp_tail_q;
        rsp_error_d = rsp_error_q;
        ld_error_d  = ld_fire && !ld_in_range;

        unique case (state_q)
            INIT: begin
                cnt_d = cnt_q + IW'(1);
                if (cnt_q == IW'(DEPTH - 1)) state_d = RUN;
            end
            RUN:     state_d = RUN;
            default: state_d = INIT;
        endcase

        if (req_fire) begin
            rsp_valid_d = 1'b1;
            rsp_byte0_d = win_byte0;
            rsp_tail_d  = win_tail;
            rsp_error_d = win_error;
        end else if (bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    // The array has no reset; the INIT sweep is what clears it.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            mem_q[cnt_q] <= 8'h00;
        end else if (ld_fire && ld_in_range) begin
            mem_q[bus.ld_addr[IW-1:0]] <= bus.ld_data;
        end
    end
endmodule

// File: tb/tb_imem_fetch_unit.sv
// Directed bench for imem_fetch_unit: per-cycle model comparison plus literal expectations.
module tb_imem_fetch_unit;
    import imem_pkg::*;

    localparam int DEPTH = 2048;
    localparam int AW    = 64;
    localparam int FB    = 10;
    localparam int TW    = 8 * (FB - 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    imem_fetch_unit_if #(.AW(AW), .FETCH_BYTES(FB)) bus ();

    imem_fetch_unit #(
        .DEPTH      (DEPTH),
        .AW         (AW),
        .FETCH_BYTES(FB)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [TW-1:0] act, input logic [TW-1:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Model: a plain byte array, cleared by reset, plus the expected response slot.
    logic [7:0]    model_mem [DEPTH];
    int            cyc;
    logic          m_valid;
    logic          m_ld_err;
    logic [7:0]    m_b0;
    logic [TW-1:0] m_tail;
    logic          m_err;

    function automatic void model_fetch(input logic [AW-1:0] pc, output logic [7:0] b0,
                                        output logic [TW-1:0] t, output logic e);
        logic [AW:0] a;
        b0 = '0;
        t  = '0;
        e  = (pc >= AW'(DEPTH));
        if (!e) begin
            b0 = model_mem[int'(pc)];
            for (int k = 0; k < FB - 1; k++) begin
                a = {1'b0, pc} + (AW+1)'(k + 1);
                if (a < (AW+1)'(DEPTH)) t[8*k +: 8] = model_mem[int'(a)];
            end
        end
    endfunction

    always @(negedge clk) begin
        logic exp_run, exp_req_ready, ld_fire, req_fire;
        if (!rst_n) begin
            chk("mon_rst_rsp_valid", TW'(bus.rsp_valid), '0);
            chk("mon_rst_init_done", TW'(bus.init_done), '0);
            chk("mon_rst_ld_ready",  TW'(bus.ld_ready),  '0);
            chk("mon_rst_req_ready", TW'(bus.req_ready), '0);
            cyc      = 0;
            m_valid  = 1'b0;
            m_ld_err = 1'b0;
            foreach (model_mem[i]) model_mem[i] = 8'h00;
        end else begin
            exp_run       = (cyc >= DEPTH);
            exp_req_ready = exp_run && !bus.ld_valid && (!m_valid || bus.rsp_ready);
            chk("mon_init_done", TW'(bus.init_done), TW'(exp_run));
            chk("mon_ld_ready",  TW'(bus.ld_ready),  TW'(exp_run));
            chk("mon_req_ready", TW'(bus.req_ready), TW'(exp_req_ready));
            chk("mon_rsp_valid", TW'(bus.rsp_valid), TW'(m_valid));
            chk("mon_ld_error",  TW'(bus.ld_error),  TW'(m_ld_err));
            if (m_valid) begin
                chk("mon_rsp_byte0", TW'(bus.rsp_byte0), TW'(m_b0));
                chk("mon_rsp_tail",  bus.rsp_tail,       m_tail);
                chk("mon_rsp_error", TW'(bus.rsp_error), TW'(m_err));
            end
            ld_fire  = bus.ld_valid && exp_run;
            req_fire = bus.req_valid && exp_req_ready;
            m_ld_err = ld_fire && (bus.ld_addr >= AW'(DEPTH));
            if (req_fire) begin
                model_fetch(bus.req_pc, m_b0, m_tail, m_err);
                m_valid = 1'b1;
            end else if (bus.rsp_ready) begin
                m_valid = 1'b0;
            end
            if (ld_fire && bus.ld_addr < AW'(DEPTH)) model_mem[int'(bus.ld_addr)] = bus.ld_data;
            cyc++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [AW-1:0] a, input logic [7:0] d);
        bus.ld_valid = 1'b1;
        bus.ld_addr  = a;
        bus.ld_data  = d;
        tick();
        bus.ld_valid = 1'b0;
        $display("load  addr=%0d data=%02h ld_error=%0b", a, d, bus.ld_error);
    endtask

    task automatic fetch(input string name, input logic [AW-1:0] pc, input logic [7:0] eb0,
                         input logic [TW-1:0] et, input logic ee);
        bus.req_valid = 1'b1;
        bus.req_pc    = pc;
        bus.rsp_ready = 1'b1;
        tick();
        bus.req_valid = 1'b0;
        chk({name, "_valid"}, TW'(bus.rsp_valid), TW'(1'b1));
        chk({name, "_byte0"}, TW'(bus.rsp_byte0), TW'(eb0));
        chk({name, "_tail"},  bus.rsp_tail,       et);
        chk({name, "_error"}, TW'(bus.rsp_error), TW'(ee));
        $display("fetch %s pc=%0h byte0=%02h tail=%018h err=%0b",
                 name, pc, bus.rsp_byte0, bus.rsp_tail, bus.rsp_error);
        tick();
    endtask

    task automatic wait_init(input string name);
        int n = 0;
        while (!bus.init_done && n < 3000) begin
            tick();
            n++;
        end
        chk(name, TW'(n), TW'(DEPTH));
        $display("init  %s took %0d cycles", name, n);
    endtask

    initial begin
        int n;
        bus.ld_valid  = 1'b0;
        bus.ld_addr   = '0;
        bus.ld_data   = '0;
        bus.req_valid = 1'b0;
        bus.req_pc    = '0;
        bus.rsp_ready = 1'b1;
        rst_n         = 1'b0;
        repeat (3) tick();
        chk("rst_rsp_valid", TW'(bus.rsp_valid), '0);
        chk("rst_rsp_byte0", TW'(bus.rsp_byte0), '0);
        chk("rst_rsp_tail",  bus.rsp_tail,       '0);
        chk("rst_rsp_error", TW'(bus.rsp_error), '0);
        chk("rst_ld_error",  TW'(bus.ld_error),  '0);
        chk("rst_init_done", TW'(bus.init_done), '0);

        // Traffic offered during the clear sweep must be refused.
        rst_n         = 1'b1;
        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 64'd7;
        bus.ld_data   = 8'h55;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'd7;
        n = 0;
        while (!bus.init_done && n < 3000) begin
            tick();
            n++;
            if (n == 100) begin
                bus.ld_valid  = 1'b0;
                bus.req_valid = 1'b0;
            end
        end
        chk("init_cycles", TW'(n), TW'(DEPTH));
        $display("init  first sweep took %0d cycles", n);

        fetch("blank100", 64'd100, 8'h00, '0, 1'b0);
        fetch("blank7",   64'd7,   8'h00, '0, 1'b0);

        load(64'd1, make_op(ICODE_IRMOVQ, 4'h0));
        load(64'd2, 8'hF8);
        load(64'd3, 8'h0A);
        for (int a = 4; a <= 10; a++) load(AW'(a), 8'h00);
        load(64'd11, make_op(ICODE_OPQ, 4'h0));
        load(64'd21, make_op(ICODE_JXX, 4'h0));
        fetch("irmovq", 64'd1, 8'h30, 72'h0AF8, 1'b0);

        load(64'd2046, 8'hAA);
        load(64'd2047, 8'hBB);
        fetch("edge2046", 64'd2046, 8'hAA, 72'hBB, 1'b0);
        fetch("edge2048", 64'd2048, 8'h00, '0, 1'b1);
        fetch("pcmax", 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, '0, 1'b1);

        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'd1;
        tick();
        bus.req_pc = 64'd11;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("bp_hold_valid", TW'(bus.rsp_valid), TW'(1'b1));
            chk("bp_hold_byte0", TW'(bus.rsp_byte0), TW'(8'h30));
            chk("bp_req_ready",  TW'(bus.req_ready), '0);
            $display("stall cycle %0d byte0=%02h req_ready=%0b", i, bus.rsp_byte0, bus.req_ready);
        end
        bus.rsp_ready = 1'b1;
        #1;
        chk("bp_rel_req_ready", TW'(bus.req_ready), TW'(1'b1));
        chk("bp_rsp1_byte0",    TW'(bus.rsp_byte0), TW'(8'h30));
        tick();
        bus.req_pc = 64'd21;
        chk("bp_rsp2_valid", TW'(bus.rsp_valid), TW'(1'b1));
        chk("bp_rsp2_byte0", TW'(bus.rsp_byte0), TW'(8'h60));
        tick();
        bus.req_valid = 1'b0;
        chk("bp_rsp3_valid", TW'(bus.rsp_valid), TW'(1'b1));
        chk("bp_rsp3_byte0", TW'(bus.rsp_byte0), TW'(8'h70));
        tick();
        chk("bp_drained", TW'(bus.rsp_valid), '0);
        $display("backpressure sequence pc=1,11,21 complete");

        bus.ld_valid  = 1'b1;
        bus.ld_addr   = 64'd5;
        bus.ld_data   = 8'h77;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'd5;
        #1;
        chk("conf_req_ready", TW'(bus.req_ready), '0);
        chk("conf_ld_ready",  TW'(bus.ld_ready),  TW'(1'b1));
        tick();
        bus.ld_valid = 1'b0;
        tick();
        bus.req_valid = 1'b0;
        chk("conf_rsp_valid", TW'(bus.rsp_valid), TW'(1'b1));
        chk("conf_rsp_byte0", TW'(bus.rsp_byte0), TW'(8'h77));
        $display("conflict load 5<=77 then fetch byte0=%02h", bus.rsp_byte0);
        tick();

        load(64'd4096, 8'h99);
        chk("oob_ld_error_pulse", TW'(bus.ld_error), TW'(1'b1));
        tick();
        chk("oob_ld_error_clear", TW'(bus.ld_error), '0);
        fetch("after_oob", 64'd0, 8'h00, 72'h77000AF830, 1'b0);

        bus.rsp_ready = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_pc    = 64'd1;
        tick();
        bus.req_valid = 1'b0;
        chk("mid_rsp_valid", TW'(bus.rsp_valid), TW'(1'b1));
        rst_n = 1'b0;
        #1;
        chk("mid_async_drop", TW'(bus.rsp_valid), '0);
        chk("mid_init_done",  TW'(bus.init_done), '0);
        $display("reset asserted mid-response rsp_valid=%0b", bus.rsp_valid);
        bus.rsp_ready = 1'b1;
        repeat (2) tick();
        rst_n = 1'b1;
        wait_init("reinit_cycles");
        fetch("reinit_pc1", 64'd1, 8'h00, '0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
